neural_network_pipe: RTL
========================

// Module: neural_network_pipe
// PURPOSE
// Parametrised, fully pipelined two-layer perceptron pixel classifier (skin detection) for the video path.
// Accepts one N_IN-feature pixel per ce cycle (default R,G,B,H,S,Cb,Cr) and emits a per-pixel score or binary mask.
// Coefficients are runtime-loadable into a double-buffered bank that swaps only at frame start.
// de/hsync/vsync are delayed to match the datapath latency exactly.
// PARAMETERS
// N_IN     7   input features per pixel
// N_HID    13  hidden neurons
// IN_W     8   feature width (unsigned); also hidden-activation and skin output width
// W_W      18  coefficient width (signed two's complement)
// FRAC     10  fractional bits of coefficients
// OUT_MODE 0   0 = skin is saturated score; 1 = binary mask
// THRESH   128 mask threshold on score (OUT_MODE=1 only)
// PORTS
// clk         in   1              pixel clock, all logic rising-edge
// rst_n       in   1              asynchronous active-low reset
// ce          in   1              clock enable; pipeline and sync delay advance only when 1
// de_in       in   1              data enable
// hsync_in    in   1              horizontal sync
// vsync_in    in   1              vertical sync
// feat_in     in   N_IN*IN_W      features, feature i at [i*IN_W +: IN_W]
// cfg_we      in   1              coefficient write strobe (independent of ce)
// cfg_addr    in   $clog2(CN)     coefficient address, CN = N_HID*N_IN+N_HID+N_HID+1
// cfg_data    in   W_W            coefficient value
// cfg_commit  in   1              request bank swap at next frame start
// cfg_pending out  1              swap requested, not yet done; cfg writes ignored while 1
// skin        out  IN_W           classification result
// de_out      out  1              de_in delayed by LAT ce cycles
// hsync_out   out  1              hsync_in delayed by LAT ce cycles
// vsync_out   out  1              vsync_in delayed by LAT ce cycles
// BEHAVIOUR
// - Reset (async, rst_n=0): all pipeline regs, skin, de/hsync/vsync_out, cfg_pending = 0; both banks 0; active bank = A.
// - Address map: hidden weight (j,i) at j*N_IN+i; hidden bias j at N_HID*N_IN+j; output weight j at
//   N_HID*N_IN+N_HID+j; output bias at CN-1. Writes to addr >= CN ignored. Writes always hit the shadow bank.
// - Commit: cfg_commit=1 with cfg_pending=0 sets cfg_pending next clk. Swap occurs on first ce cycle
//   with vsync_in=1 and registered previous ce-sampled vsync=0 (rising edge); same edge clears cfg_pending.
//   Commit while pending: no effect. cfg_we and commit in same cycle: write lands, then pending set.
// - After swap, the old active bank becomes shadow and keeps its contents (software rewrites fully).
// - Arithmetic: h_acc_j = sum_i feat_i*hw_ji + hb_j, full precision (no overflow); h_j = clamp(h_acc_j>>>FRAC, 0, 2^IN_W-1).
//   o_acc = sum_j h_j*ow_j + ob; score = clamp(o_acc>>>FRAC, 0, 2^IN_W-1). Arithmetic shift (floor).
// - Output: OUT_MODE=0 skin = score; OUT_MODE=1 skin = (score >= THRESH) ? all-ones : 0.
// - Pipeline, LAT = 6 ce cycles: S1 input products; S2 hidden sum+bias; S3 hidden clamp;
//   S4 output products; S5 output sum+bias; S6 clamp/threshold -> skin register.
// - Sync delay: shift register depth LAT, advanced with ce; outputs always aligned with skin.
// - ce=0: every pipeline/sync register holds; cfg writes still accepted; no swap.
// - Swap is atomic w.r.t. pixels: pixel entering S1 on swap cycle uses the new bank in all stages
//   (coefficients travel with pipeline, or bank select is pipelined per stage).
// - Mid-frame reset: pipeline flushes to 0, pending commit lost, both banks cleared.
// TESTING
// - Reset: rst_n=0 mid-stream -> skin=0, syncs=0, cfg_pending=0 immediately (async), no X after release.
// - Latency: all coeffs 0 except ob=5<<FRAC, commit, vsync edge; de pulse -> de_out and skin=5 exactly 6 ce cycles later.
// - Hidden path: hw(0,0)=1<<FRAC, ow0=1<<FRAC, feat0=200 -> skin=200; feat0=255,hw=2<<FRAC -> skin=255 (sat); hw=-1<<FRAC -> 0.
// - Mask mode OUT_MODE=1, THRESH=128: scores 127,128,200 -> skin 0x00,0xFF,0xFF.
// - Bank swap: load bank, commit, stream mid-frame -> old coeffs until vsync rise; cfg_we while pending ignored.
// - ce gating: ce toggled 1/0 randomly -> outputs match ce=1 model after 6 ce-high cycles; addr>=CN write no effect.

Source files
------------

// File: rtl/neural_network_pipe.sv
// Two-layer perceptron pixel classifier (skin detection) with a double-buffered coefficient bank.
// Latency: LAT = 6 ce cycles from feat_in/de/hsync/vsync to skin/de_out/hsync_out/vsync_out.
// Backpressure: none; ce=0 freezes every pipeline and sync register, cfg writes still land.
//
// Ports:
//   clk, rst_n            pixel clock, asynchronous active-low reset
//   ce                    clock enable for the pixel pipeline and sync delay
//   de_in/hsync_in/...    video timing, delayed by LAT to de_out/hsync_out/vsync_out
//   feat_in               N_IN unsigned features, feature i at [i*IN_W +: IN_W]
//   cfg_we/addr/data      coefficient write into the shadow bank
//   cfg_commit            request a bank swap at the next vsync rising edge
//   cfg_pending           swap requested but not yet done; writes ignored meanwhile
//   skin                  saturated score (OUT_MODE=0) or binary mask (OUT_MODE=1)
module neural_network_pipe #(
   parameter int N_IN     = 7,
   parameter int N_HID    = 13,
   parameter int IN_W     = 8,
   parameter int W_W      = 18,
   parameter int FRAC     = 10,
   parameter int OUT_MODE = 0,
   parameter int THRESH   = 128
) (
   input  logic                                       clk,
   input  logic                                       rst_n,
   input  logic                                       ce,
   input  logic                                       de_in,
   input  logic                                       hsync_in,
   input  logic                                       vsync_in,
   input  logic [N_IN*IN_W-1:0]                       feat_in,
   input  logic                                       cfg_we,
   input  logic [$clog2(N_HID*N_IN+2*N_HID+1)-1:0]    cfg_addr,
   input  logic [W_W-1:0]                             cfg_data,
   input  logic                                       cfg_commit,
   output logic                                       cfg_pending,
   output logic [IN_W-1:0]                            skin,
   output logic                                       de_out,
   output logic                                       hsync_out,
   output logic                                       vsync_out
);

   localparam int CN      = N_HID*N_IN + 2*N_HID + 1;
   localparam int CAW     = $clog2(CN);
   localparam int LAT     = 6;
   localparam int HB_BASE = N_HID*N_IN;
   localparam int OW_BASE = HB_BASE + N_HID;
   localparam int OB_ADDR = CN - 1;
   // Unsigned IN_W operand widened by one sign bit, times a signed W_W coefficient.
   localparam int PW      = IN_W + W_W + 1;
   // Headroom for the larger of the two sums (products plus bias) without overflow.
   localparam int ACC_W   = PW + $clog2(N_IN + N_HID + 1) + 1;

   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << IN_W) - 1);
   localparam logic [IN_W-1:0]         THR     = IN_W'(THRESH);
   // When CN is a power of two every address is valid and CAW'(CN) would wrap to 0.
   localparam bit                      ALL_OK  = (CN == (1 << CAW));
   localparam logic [CAW-1:0]          CN_A    = CAW'(CN);

   // ---------------------------------------------------------------
   // Coefficient banks and swap control
   // ---------------------------------------------------------------
   logic signed [W_W-1:0] bank_a [CN];
   logic signed [W_W-1:0] bank_b [CN];
   logic                  act_sel;   // 0: bank A active, 1: bank B active
   logic                  vs_prev;   // vsync sampled on the previous ce cycle
   logic                  swap;
   logic                  addr_ok;
   logic                  bsel0;     // bank used by the pixel entering S1 this cycle

   assign swap    = ce & vsync_in & ~vs_prev & cfg_pending;
   assign addr_ok = ALL_OK | (cfg_addr < CN_A);
   // The pixel that enters on the swap cycle already belongs to the new bank.
   assign bsel0   = act_sel ^ swap;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < CN; k++) begin
            bank_a[k] <= '0;
            bank_b[k] <= '0;
         end
      end else if (cfg_we && !cfg_pending && addr_ok) begin
         // Writes always target the bank that is not currently active.
         if (act_sel)
            bank_a[cfg_addr] <= cfg_data;
         else
            bank_b[cfg_addr] <= cfg_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_sel     <= 1'b0;
         cfg_pending <= 1'b0;
         vs_prev     <= 1'b0;
      end else begin
         if (ce)
            vs_prev <= vsync_in;
         if (swap) begin
            act_sel     <= ~act_sel;
            cfg_pending <= 1'b0;
         end else if (cfg_commit && !cfg_pending) begin
            cfg_pending <= 1'b1;
         end
      end
   end

   function automatic logic signed [W_W-1:0] coef(input logic sel, input int idx);
      return sel ? bank_b[idx] : bank_a[idx];
   endfunction

   // floor(a / 2^FRAC) clamped to [0, 2^IN_W-1]
   function automatic logic [IN_W-1:0] sat(input logic signed [ACC_W-1:0] a);
      logic signed [ACC_W-1:0] s;
      s = a >>> FRAC;
      if (s < 0)
         return '0;
      else if (s > SAT_MAX)
         return '1;
      else
         return s[IN_W-1:0];
   endfunction

   // ---------------------------------------------------------------
   // Pipeline registers. bsel[k] is the bank owning the pixel held in
   // stage k, so a stage reading coefficients uses its own pixel's bank.
   // ---------------------------------------------------------------
   logic [4:1]              bsel;
   logic signed [PW-1:0]    prod1_q [N_HID][N_IN];   // S1
   logic signed [ACC_W-1:0] hacc_q  [N_HID];         // S2
   logic [IN_W-1:0]         h_q     [N_HID];         // S3
   logic signed [PW-1:0]    prod2_q [N_HID];         // S4
   logic signed [ACC_W-1:0] oacc_q;                  // S5
   logic [LAT-1:0]          de_sr;
   logic [LAT-1:0]          hs_sr;
   logic [LAT-1:0]          vs_sr;

   logic signed [PW-1:0]    prod1_d [N_HID][N_IN];
   logic signed [ACC_W-1:0] hacc_d  [N_HID];
   logic [IN_W-1:0]         h_d     [N_HID];
   logic signed [PW-1:0]    prod2_d [N_HID];
   logic signed [ACC_W-1:0] oacc_d;
   logic [IN_W-1:0]         score_d;
   logic [IN_W-1:0]         skin_d;

   // S1: input products
   always_comb begin
      for (int j = 0; j < N_HID; j++) begin
         for (int i = 0; i < N_IN; i++) begin
            prod1_d[j][i] = $signed({{(PW-IN_W){1'b0}}, feat_in[i*IN_W +: IN_W]})
                            * PW'(coef(bsel0, j*N_IN + i));
         end
      end
   end

   // S2: hidden sums with bias
   always_comb begin
      for (int j = 0; j < N_HID; j++) begin
         hacc_d[j] = ACC_W'(coef(bsel[1], HB_BASE + j));
         for (int i = 0; i < N_IN; i++)
            hacc_d[j] = hacc_d[j] + ACC_W'(prod1_q[j][i]);
      end
   end

   // S3: hidden activation clamp
   always_comb begin
      for (int j = 0; j < N_HID; j++)
         h_d[j] = sat(hacc_q[j]);
   end

   // S4: output products
   always_comb begin
      for (int j = 0; j < N_HID; j++)
         prod2_d[j] = $signed({{(PW-IN_W){1'b0}}, h_q[j]}) * PW'(coef(bsel[3], OW_BASE + j));
   end

   // S5: output sum with bias
   always_comb begin
      oacc_d = ACC_W'(coef(bsel[4], OB_ADDR));
      for (int j = 0; j < N_HID; j++)
         oacc_d = oacc_d + ACC_W'(prod2_q[j]);
   end

   // S6: clamp and optional threshold
   always_comb begin
      score_d = sat(oacc_q);
      skin_d  = score_d;
      if (OUT_MODE == 1)
         skin_d = (score_d >= THR) ? '1 : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bsel   <= '0;
         oacc_q <= '0;
         skin   <= '0;
         de_sr  <= '0;
         hs_sr  <= '0;
         vs_sr  <= '0;
         for (int j = 0; j < N_HID; j++) begin
            hacc_q[j]  <= '0;
            h_q[j]     <= '0;
            prod2_q[j] <= '0;
            for (int i = 0; i < N_IN; i++)
               prod1_q[j][i] <= '0;
         end
      end else if (ce) begin
         bsel   <= {bsel[3:1], bsel0};
         oacc_q <= oacc_d;
         skin   <= skin_d;
         de_sr  <= {de_sr[LAT-2:0], de_in};
         hs_sr  <= {hs_sr[LAT-2:0], hsync_in};
         vs_sr  <= {vs_sr[LAT-2:0], vsync_in};
         for (int j = 0; j < N_HID; j++) begin
            hacc_q[j]  <= hacc_d[j];
            h_q[j]     <= h_d[j];
            prod2_q[j] <= prod2_d[j];
            for (int i = 0; i < N_IN; i++)
               prod1_q[j][i] <= prod1_d[j][i];
         end
      end
   end

   assign de_out    = de_sr[LAT-1];
   assign hsync_out = hs_sr[LAT-1];
   assign vsync_out = vs_sr[LAT-1];

endmodule
